// File: rtl/slope_adc_pkg.sv
// Shared types and constants for the single-slope ADC sequencer.
package slope_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISCHARGE,
        SETTLE,
        RAMP,
        HOLD
    } state_e;

    localparam int AVG_SHIFT     = 2;
    localparam int CNT_W_DEFAULT = 12;

endpackage

// File: rtl/slope_adc_sequencer_comp_sync.sv
// Multi-flop synchroniser for the asynchronous comparator input; output resets to 0.
module comp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/slope_adc_sequencer.sv
// Single-slope ramp ADC sequencer: discharge, settle, count until comparator trip, hand off sample.
// Optional SLOPE_ADC_AVG_EN: each request averages 4 conversions.
module slope_adc_sequencer
    import slope_adc_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DISCH_CYC   = 64,
    parameter int SETTLE_CYC  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             hf_osc,
    input  logic             rst,
    input  logic             start_i,
    input  logic             free_run_i,
    input  logic             comp_i,
    output logic             ramp_dis_o,
    output logic             ramp_en_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] sample_o,
    output logic             overflow_o,
    output logic             sample_valid_o,
    input  logic             sample_ready_i
);

    localparam int TMR_MAX = (DISCH_CYC > SETTLE_CYC) ? DISCH_CYC : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] DISCH_LAST  = TMR_W'(DISCH_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   sample_q, sample_d;
    logic               ovf_q, ovf_d;
    logic               busy_q;
    logic               comp_s;
    logic               done;
    logic [CNT_W-1:0]   res;
    logic               res_ovf;

    comp_sync #(.STAGES(SYNC_STAGES)) u_comp_sync (
        .clk_i (hf_osc),
        .rst_i (rst),
        .d_i   (comp_i),
        .q_o   (comp_s)
    );

`ifdef SLOPE_ADC_AVG_EN
    logic [1:0]       conv_q, conv_d;
    logic [CNT_W+1:0] acc_q, acc_d, acc_sum;
    logic             ovf_acc_q, ovf_acc_d;
`endif

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        ovf_d      = ovf_q;
        ramp_dis_o = 1'b1;
        ramp_en_o  = 1'b0;
        done       = 1'b0;
        res        = '0;
        res_ovf    = 1'b0;
`ifdef SLOPE_ADC_AVG_EN
        conv_d     = conv_q;
        acc_d      = acc_q;
        ovf_acc_d  = ovf_acc_q;
        acc_sum    = '0;
`endif
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (start_i || free_run_i) state_d = DISCHARGE;
            end
            DISCHARGE: begin
                if (tmr_q == DISCH_LAST) begin
                    tmr_d   = '0;
                    state_d = SETTLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            SETTLE: begin
                ramp_dis_o = 1'b0;
                if (tmr_q == SETTLE_LAST) begin
                    tmr_d   = '0;
                    cnt_d   = '0;
                    state_d = RAMP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RAMP: begin
                ramp_dis_o = 1'b0;
                ramp_en_o  = 1'b1;
                // Trip wins over saturation so a trip on the last count is not flagged.
                if (comp_s) begin
                    done = 1'b1;
                    res  = cnt_q;
                end else if (cnt_q == CNT_MAX) begin
                    done    = 1'b1;
                    res     = CNT_MAX;
                    res_ovf = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (sample_ready_i) state_d = free_run_i ? DISCHARGE : IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef SLOPE_ADC_AVG_EN
        acc_sum = acc_q + (CNT_W+2)'(res);
        if (done) begin
            if (conv_q == 2'd3) begin
                sample_d  = acc_sum[AVG_SHIFT +: CNT_W];
                ovf_d     = ovf_acc_q | res_ovf;
                acc_d     = '0;
                conv_d    = '0;
                ovf_acc_d = 1'b0;
                state_d   = HOLD;
            end else begin
                acc_d     = acc_sum;
                conv_d    = conv_q + 1'b1;
                ovf_acc_d = ovf_acc_q | res_ovf;
                state_d   = DISCHARGE;
            end
        end
`else
        if (done) begin
            sample_d = res;
            ovf_d    = res_ovf;
            state_d  = HOLD;
        end
`endif
    end

    always_ff @(posedge hf_osc or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            ovf_q    <= ovf_d;
            busy_q   <= (state_d != IDLE);
        end
    end

`ifdef SLOPE_ADC_AVG_EN
    always_ff @(posedge hf_osc or posedge rst) begin
        if (rst) begin
            conv_q    <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
        end else begin
            conv_q    <= conv_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
        end
    end
`endif

    assign busy_o         = busy_q;
    assign sample_o       = sample_q;
    assign overflow_o     = ovf_q;
    assign sample_valid_o = (state_q == HOLD);

endmodule

// File: tb/tb_slope_adc_sequencer.sv
// Directed self-checking bench for slope_adc_sequencer (CNT_W=8, DISCH_CYC=4, SETTLE_CYC=2).
module tb_slope_adc_sequencer;

    localparam int CNT_W = 8;

    logic             hf_osc = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic             free_run_i = 1'b0;
    logic             comp_i = 1'b0;
    logic             sample_ready_i = 1'b0;
    logic             ramp_dis_o, ramp_en_o, busy_o, overflow_o, sample_valid_o;
    logic [CNT_W-1:0] sample_o;

    int errors = 0;
    int checks = 0;

    always #5 hf_osc = ~hf_osc;

    slope_adc_sequencer #(
        .CNT_W(CNT_W), .DISCH_CYC(4), .SETTLE_CYC(2), .SYNC_STAGES(2)
    ) dut (
        .hf_osc         (hf_osc),
        .rst            (rst),
        .start_i        (start_i),
        .free_run_i     (free_run_i),
        .comp_i         (comp_i),
        .ramp_dis_o     (ramp_dis_o),
        .ramp_en_o      (ramp_en_o),
        .busy_o         (busy_o),
        .sample_o       (sample_o),
        .overflow_o     (overflow_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i)
    );

    task automatic step();
        @(posedge hf_osc);
        #1;
    endtask

    // From IDLE: request a conversion and walk to RAMP cycle 0 (4 discharge + 2 settle).
    task automatic enter_ramp();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ramp_dis_o, ramp_en_o, busy_o, sample_valid_o, overflow_o} !== 5'b10000 || sample_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got dis/en/busy/vld/ovf=%b sample=%0d exp=10000 sample=0",
                     {ramp_dis_o, ramp_en_o, busy_o, sample_valid_o, overflow_o}, sample_o);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({ramp_dis_o, busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL reset_idle got dis/busy=%b exp=10", {ramp_dis_o, busy_o});
        end
    endtask

    task automatic test_single();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ramp_dis_o, ramp_en_o, busy_o} !== 3'b101) begin
                errors++;
                $display("FAIL single_disch%0d got dis/en/busy=%b exp=101", i, {ramp_dis_o, ramp_en_o, busy_o});
            end
            if (i == 1) start_i = 1'b1;
            step();
            start_i = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({ramp_dis_o, ramp_en_o, busy_o} !== 3'b001) begin
                errors++;
                $display("FAIL single_settle%0d got dis/en/busy=%b exp=001", i, {ramp_dis_o, ramp_en_o, busy_o});
            end
            step();
        end
        checks++;
        if ({ramp_dis_o, ramp_en_o, busy_o} !== 3'b011) begin
            errors++;
            $display("FAIL single_ramp0 got dis/en/busy=%b exp=011", {ramp_dis_o, ramp_en_o, busy_o});
        end
        repeat (100) step();
        comp_i = 1'b1;
        step();
        step();
        checks++;
        if ({sample_valid_o, ramp_en_o} !== 2'b01) begin
            errors++;
            $display("FAIL single_pre_hold got vld/en=%b exp=01", {sample_valid_o, ramp_en_o});
        end
        step();
        comp_i = 1'b0;
        checks++;
        if ({sample_valid_o, busy_o, ramp_dis_o, ramp_en_o, overflow_o} !== 5'b11100 || sample_o !== 8'd102) begin
            errors++;
            $display("FAIL single_hold got vld/busy/dis/en/ovf=%b sample=%0d exp=11100 sample=102",
                     {sample_valid_o, busy_o, ramp_dis_o, ramp_en_o, overflow_o}, sample_o);
        end
        sample_ready_i = 1'b1;
        step();
        sample_ready_i = 1'b0;
        checks++;
        if ({sample_valid_o, busy_o, ramp_dis_o} !== 3'b001) begin
            errors++;
            $display("FAIL single_idle got vld/busy/dis=%b exp=001", {sample_valid_o, busy_o, ramp_dis_o});
        end
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_no_queue got busy=%b exp=0", busy_o);
        end
    endtask

    task automatic test_no_trip();
        enter_ramp();
        repeat (255) step();
        checks++;
        if ({sample_valid_o, ramp_en_o} !== 2'b01) begin
            errors++;
            $display("FAIL notrip_r255 got vld/en=%b exp=01", {sample_valid_o, ramp_en_o});
        end
        step();
        checks++;
        if ({sample_valid_o, overflow_o} !== 2'b11 || sample_o !== 8'd255) begin
            errors++;
            $display("FAIL notrip_hold got vld/ovf=%b sample=%0d exp=11 sample=255",
                     {sample_valid_o, overflow_o}, sample_o);
        end
        sample_ready_i = 1'b1;
        step();
        sample_ready_i = 1'b0;
        checks++;
        if ({sample_valid_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL notrip_idle got vld/busy=%b exp=00", {sample_valid_o, busy_o});
        end
    endtask

    task automatic test_backpressure();
        enter_ramp();
        repeat (20) step();
        comp_i = 1'b1;
        step();
        comp_i = 1'b0;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({sample_valid_o, overflow_o, sample_o} !== {1'b1, 1'b0, 8'd22}) begin
                errors++;
                $display("FAIL bp_hold%0d got vld/ovf=%b sample=%0d exp=10 sample=22",
                         i, {sample_valid_o, overflow_o}, sample_o);
            end
            step();
        end
        sample_ready_i = 1'b1;
        step();
        sample_ready_i = 1'b0;
        checks++;
        if ({sample_valid_o, busy_o, ramp_dis_o, ramp_en_o} !== 4'b0010 || sample_o !== 8'd22) begin
            errors++;
            $display("FAIL bp_after got vld/busy/dis/en=%b sample=%0d exp=0010 sample=22",
                     {sample_valid_o, busy_o, ramp_dis_o, ramp_en_o}, sample_o);
        end
    endtask

    task automatic test_free_run();
        sample_ready_i = 1'b1;
        free_run_i = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            repeat (6) step();
            if (c == 2) free_run_i = 1'b0;
            repeat (10) step();
            comp_i = 1'b1;
            step();
            comp_i = 1'b0;
            step();
            step();
            checks++;
            if ({sample_valid_o, busy_o, ramp_dis_o, ramp_en_o, overflow_o} !== 5'b11100 || sample_o !== 8'd12) begin
                errors++;
                $display("FAIL free_sample%0d got vld/busy/dis/en/ovf=%b sample=%0d exp=11100 sample=12",
                         c, {sample_valid_o, busy_o, ramp_dis_o, ramp_en_o, overflow_o}, sample_o);
            end
            step();
            checks++;
            if (c < 2) begin
                if ({sample_valid_o, busy_o, ramp_dis_o, ramp_en_o} !== 4'b0110) begin
                    errors++;
                    $display("FAIL free_restart%0d got vld/busy/dis/en=%b exp=0110",
                             c, {sample_valid_o, busy_o, ramp_dis_o, ramp_en_o});
                end
            end else begin
                if ({sample_valid_o, busy_o, ramp_dis_o, ramp_en_o} !== 4'b0010) begin
                    errors++;
                    $display("FAIL free_stop got vld/busy/dis/en=%b exp=0010",
                             {sample_valid_o, busy_o, ramp_dis_o, ramp_en_o});
                end
            end
        end
        sample_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        enter_ramp();
        repeat (50) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({ramp_dis_o, ramp_en_o, busy_o, sample_valid_o, overflow_o} !== 5'b10000 || sample_o !== 8'd0) begin
            errors++;
            $display("FAIL rstmid_async got dis/en/busy/vld/ovf=%b sample=%0d exp=10000 sample=0",
                     {ramp_dis_o, ramp_en_o, busy_o, sample_valid_o, overflow_o}, sample_o);
        end
        step();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({sample_valid_o, busy_o, ramp_dis_o} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_after got vld/busy/dis=%b exp=001", {sample_valid_o, busy_o, ramp_dis_o});
        end
    endtask

`ifdef SLOPE_ADC_AVG_EN
    task automatic test_avg();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (6) step();
            repeat (8 + k) step();
            comp_i = 1'b1;
            step();
            comp_i = 1'b0;
            step();
            step();
            checks++;
            if (k < 3) begin
                if ({sample_valid_o, busy_o, ramp_dis_o, ramp_en_o} !== 4'b0110) begin
                    errors++;
                    $display("FAIL avg_between%0d got vld/busy/dis/en=%b exp=0110",
                             k, {sample_valid_o, busy_o, ramp_dis_o, ramp_en_o});
                end
            end else begin
                if ({sample_valid_o, overflow_o, sample_o} !== {1'b1, 1'b0, 8'd11}) begin
                    errors++;
                    $display("FAIL avg_sample got vld/ovf=%b sample=%0d exp=10 sample=11",
                             {sample_valid_o, overflow_o}, sample_o);
                end
            end
        end
        sample_ready_i = 1'b1;
        step();
        sample_ready_i = 1'b0;
        checks++;
        if ({sample_valid_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL avg_idle got vld/busy=%b exp=00", {sample_valid_o, busy_o});
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef SLOPE_ADC_AVG_EN
        test_avg();
`else
        test_single();
        test_no_trip();
        test_backpressure();
        test_free_run();
        test_reset_mid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slope_adc_sequencer.md
Name: slope_adc_sequencer

Overview:
- Sequences a single-slope (ramp) conversion built around the LVDS differential comparator input and the externally generated ramp.
- Per conversion: discharges the ramp capacitor, releases it, counts clock cycles while the ramp runs, and stops counting when the comparator trips.
- Presents the count as a sample on a valid/ready handshake.
- Sits between the comparator SB_IO (D_IN_0) and the ramp-drive pins on one side, and the consumer logic (audio/readout) on the other.

Parameters:
- CNT_W, 12, width of the conversion counter and of sample_o.
- DISCH_CYC, 64, cycles ramp_dis_o is held asserted in DISCHARGE (≥1).
- SETTLE_CYC, 4, cycles between discharge release and ramp start (≥1).
- SYNC_STAGES, 2, flops in the comparator synchroniser (≥2).

Ports:
- hf_osc, input, 1, system clock (HFOSC-derived); all logic on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- start_i, input, 1, request one conversion; level sampled in IDLE.
- free_run_i, input, 1, 1 = start the next conversion automatically after each handshake.
- comp_i, input, 1, raw comparator output from SB_IO D_IN_0; asynchronous to hf_osc.
- ramp_dis_o, output, 1, 1 = close the capacitor discharge switch.
- ramp_en_o, output, 1, 1 = enable ramp charging / ref-clock drive.
- busy_o, output, 1, high in every state except IDLE.
- sample_o, output, CNT_W, conversion result.
- overflow_o, output, 1, result saturated without a comparator trip; qualified by sample_valid_o.
- sample_valid_o, output, 1, result available.
- sample_ready_i, input, 1, consumer accepts the result.

Behaviour:
- Reset (async, rst=1): state=IDLE, ramp_dis_o=1, ramp_en_o=0, busy_o=0, sample_o=0, overflow_o=0, sample_valid_o=0, counters=0, synchroniser flops=0.
- comp_i passes through SYNC_STAGES flops to give comp_s; only comp_s is used. No latency compensation: the fixed offset of SYNC_STAGES is left to the consumer.
- FSM states: IDLE, DISCHARGE, SETTLE, RAMP, HOLD.
- IDLE:
  - Outputs: ramp_dis_o=1, ramp_en_o=0.
  - start_i=1 or free_run_i=1 at an edge → DISCHARGE on the next cycle.
- DISCHARGE:
  - Outputs: ramp_dis_o=1, ramp_en_o=0.
  - Lasts exactly DISCH_CYC cycles, then → SETTLE.
- SETTLE:
  - Outputs: ramp_dis_o=0, ramp_en_o=0.
  - Lasts exactly SETTLE_CYC cycles, then → RAMP.
  - comp_s is ignored in this state.
- RAMP:
  - Outputs: ramp_dis_o=0, ramp_en_o=1.
  - The count is 0 in the first RAMP cycle and increments by 1 each cycle.
  - In the first cycle where comp_s=1: sample_o ← current count, overflow_o ← 0, → HOLD.
  - If the count equals 2^CNT_W−1 and comp_s=0: sample_o ← all ones, overflow_o ← 1, → HOLD. The count never wraps.
  - If comp_s is already 1 in the first RAMP cycle, sample_o=0 is a legal result.
- HOLD:
  - Outputs: ramp_dis_o=1, ramp_en_o=0, sample_valid_o=1. sample_o and overflow_o stay stable until the transfer.
  - Transfer occurs on a cycle with sample_valid_o=1 and sample_ready_i=1. The next cycle has sample_valid_o=0.
  - After the transfer: → DISCHARGE if free_run_i=1, else → IDLE.
  - sample_ready_i asserted outside HOLD has no effect.
- start_i while busy_o=1 is ignored (not queued).
- free_run_i deasserted mid-conversion: the current conversion completes and delivers its sample, then → IDLE.
- rst asserted mid-conversion: immediate return to the reset values above, and the sample in flight is lost.
- busy_o is a registered decode of state≠IDLE.

Optional Feature:
- Macro: SLOPE_ADC_AVG_EN.
- Defined:
  - Each request runs 4 back-to-back conversions (DISCHARGE→SETTLE→RAMP ×4) into a CNT_W+2-bit accumulator.
  - sample_o = accumulator >> 2, truncated.
  - overflow_o = OR of the 4 overflow flags.
  - HOLD is entered only after the 4th RAMP.
- Undefined: single conversion per request as above. No accumulator logic is present.

Decomposition:
- Package slope_adc_pkg holds:
  - the state enum (IDLE, DISCHARGE, SETTLE, RAMP, HOLD);
  - the AVG_SHIFT=2 constant;
  - the default CNT_W.
- One natural sub-module: comp_sync (SYNC_STAGES-deep flop chain with a reset-to-0 output).

Test Plan (CNT_W=8, DISCH_CYC=4, SETTLE_CYC=2, SYNC_STAGES=2):
- Single conversion:
  - Stimulus: pulse start_i for 1 cycle. Hold comp_i=0, then raise it just before the edge that ends RAMP cycle 100.
  - Required: ramp_dis_o high for 4 cycles, low for 2 cycles, then ramp_en_o high; sample_o=102, overflow_o=0, sample_valid_o=1, busy_o=1.
- No trip:
  - Stimulus: comp_i held at 0.
  - Required: HOLD after 256 RAMP cycles with sample_o=255 and overflow_o=1.
- Backpressure:
  - Stimulus: sample_ready_i=0 for 20 cycles, then 1.
  - Required: sample_o stays stable throughout; sample_valid_o drops the cycle after the transfer; with free_run_i=0, state=IDLE and ramp_dis_o=1.
- Free run:
  - Stimulus: free_run_i=1, sample_ready_i=1, comp_i tripping at RAMP cycle 10 each conversion.
  - Required: continuous samples of 12; DISCHARGE restarts the cycle after each transfer.
- Reset mid-RAMP:
  - Stimulus: assert rst at RAMP cycle 50.
  - Required: all outputs return to reset values without waiting for a clock edge; no sample_valid_o.
- SLOPE_ADC_AVG_EN defined:
  - Stimulus: trips giving counts 10, 11, 12, 13.
  - Required: a single sample_valid_o pulse with sample_o=11 (46>>2).
